// File: rtl/clock_command_parser.sv
// ASCII command parser feeding the digital clock's time/date load, alarm,
// timer and 12/24-hour display-mode controls. Only complete, range-checked
// commands reach the outputs.
module clock_command_parser #(
  parameter int unsigned YEAR_BASE = 2000,
  parameter int unsigned YEAR_MIN  = 2020,
  parameter int unsigned YEAR_MAX  = 2025
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  output logic        cmd_ready,
  output logic [4:0]  set_hour,
  output logic [5:0]  set_min,
  output logic [5:0]  set_sec,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [11:0] set_year,
  output logic        set_load,
  output logic [4:0]  alarm_hour,
  output logic [5:0]  alarm_min,
  output logic [5:0]  alarm_sec,
  output logic        alarm_enable,
  output logic [5:0]  timer_min,
  output logic [5:0]  timer_sec,
  output logic        timer_start,
  output logic        mode_24h,
  output logic        cmd_error
);

  localparam int unsigned FW = 7;  // two decimal digits, 0..99
  localparam int unsigned NF = 6;  // most fields any command carries

  typedef enum logic [2:0] {
    S_IDLE, S_SEP_OR_END, S_D_HI, S_D_LO, S_ERR, S_EXEC
  } state_t;

  state_t         state;
  logic [2:0]     mode;
  logic [2:0]     field_idx;
  logic [FW-1:0]  acc;
  logic [FW-1:0]  fields [NF];

  logic           accept_c, is_digit_c, is_lf_c, is_cr_c, is_sp_c, fields_ok_c;
  logic [3:0]     digit_c;
  logic [2:0]     n_fields_c;
  logic [11:0]    year_c;

  // Byte classification, per-mode field count and range check of the parsed fields
  always_comb begin
    accept_c    = cmd_valid && cmd_ready;
    is_digit_c  = (cmd_byte >= 8'h30) && (cmd_byte <= 8'h39);
    is_lf_c     = (cmd_byte == 8'h0A);
    is_cr_c     = (cmd_byte == 8'h0D);
    is_sp_c     = (cmd_byte == 8'h20);
    digit_c     = 4'(cmd_byte - 8'h30);
    year_c      = 12'(YEAR_BASE) + 12'(fields[5]);
    n_fields_c  = 3'd0;
    fields_ok_c = 1'b1;
    case (mode)
      3'd3: begin
        n_fields_c  = 3'd6;
        fields_ok_c = (fields[0] <= 7'd23) && (fields[1] <= 7'd59) && (fields[2] <= 7'd59) &&
                      (fields[3] >= 7'd1) && (fields[3] <= 7'd31) &&
                      (fields[4] >= 7'd1) && (fields[4] <= 7'd12) &&
                      (year_c >= 12'(YEAR_MIN)) && (year_c <= 12'(YEAR_MAX));
      end
      3'd4: begin
        n_fields_c  = 3'd3;
        fields_ok_c = (fields[0] <= 7'd23) && (fields[1] <= 7'd59) && (fields[2] <= 7'd59);
      end
      3'd5: begin
        n_fields_c  = 3'd2;
        fields_ok_c = (fields[0] <= 7'd59) && (fields[1] <= 7'd59);
      end
      default: ;
    endcase
  end

  // Parser FSM with registered commit of control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      mode         <= 3'd0;
      field_idx    <= 3'd0;
      acc          <= '0;
      for (int i = 0; i < NF; i++) fields[i] <= '0;
      set_hour     <= '0;
      set_min      <= '0;
      set_sec      <= '0;
      set_day      <= 5'd1;
      set_month    <= 4'd1;
      set_year     <= 12'(YEAR_MIN);
      set_load     <= 1'b0;
      alarm_hour   <= '0;
      alarm_min    <= '0;
      alarm_sec    <= '0;
      alarm_enable <= 1'b0;
      timer_min    <= '0;
      timer_sec    <= '0;
      timer_start  <= 1'b0;
      mode_24h     <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      set_load    <= 1'b0;
      timer_start <= 1'b0;
      cmd_error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c && !is_cr_c) begin
            if (is_digit_c && cmd_byte <= 8'h36) begin
              mode      <= 3'(cmd_byte - 8'h30);
              field_idx <= 3'd0;
              state     <= S_SEP_OR_END;
            end else if (!is_lf_c) begin
              state <= S_ERR;
            end
          end
        end
        S_SEP_OR_END: begin
          if (accept_c && !is_cr_c) begin
            if (is_sp_c && field_idx < n_fields_c) begin
              state <= S_D_HI;
            end else if (is_lf_c && field_idx == n_fields_c) begin
              state     <= S_EXEC;
              cmd_ready <= 1'b0;
            end else if (is_lf_c) begin
              // Terminator already consumed: report now rather than wait for another LF
              cmd_error <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_D_HI: begin
          if (accept_c && !is_cr_c) begin
            if (is_digit_c) begin
              acc   <= 7'(digit_c) * 7'd10;
              state <= S_D_LO;
            end else if (is_lf_c) begin
              cmd_error <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_D_LO: begin
          if (accept_c && !is_cr_c) begin
            if (is_digit_c) begin
              fields[field_idx] <= acc + 7'(digit_c);
              field_idx         <= field_idx + 3'd1;
              state             <= S_SEP_OR_END;
            end else if (is_lf_c) begin
              cmd_error <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_ERR: begin
          if (accept_c && is_lf_c) begin
            cmd_error <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_EXEC: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
          if (!fields_ok_c) begin
            cmd_error <= 1'b1;
          end else begin
            case (mode)
              3'd0: alarm_enable <= 1'b0;
              3'd1: mode_24h     <= 1'b0;
              3'd2: mode_24h     <= 1'b1;
              3'd3: begin
                set_hour  <= 5'(fields[0]);
                set_min   <= 6'(fields[1]);
                set_sec   <= 6'(fields[2]);
                set_day   <= 5'(fields[3]);
                set_month <= 4'(fields[4]);
                set_year  <= year_c;
                set_load  <= 1'b1;
              end
              3'd4: begin
                alarm_hour   <= 5'(fields[0]);
                alarm_min    <= 6'(fields[1]);
                alarm_sec    <= 6'(fields[2]);
                alarm_enable <= 1'b1;
              end
              3'd5: begin
                timer_min   <= 6'(fields[0]);
                timer_sec   <= 6'(fields[1]);
                timer_start <= 1'b1;
              end
              3'd6: begin
                set_hour  <= '0;
                set_min   <= '0;
                set_sec   <= '0;
                set_day   <= 5'd1;
                set_month <= 4'd1;
                set_year  <= 12'd2024;
                set_load  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/clock_command_parser.md
Name: clock_command_parser

Overview:
- Upstream front end of the digital clock: consumes an ASCII command byte stream (UART receiver or testbench) and turns it into the clock's control inputs.
- Those inputs are the set-time/date values plus load strobe, the alarm time plus enable, the timer preset plus start strobe, and the 12/24-hour display mode.
- Parses the mode-digit command format, range-checks every field, and only commits complete, valid commands.

Parameters:
YEAR_BASE, 2000, added to two-digit YY to form the 12-bit year
YEAR_MIN, 2020, lowest accepted year
YEAR_MAX, 2025, highest accepted year

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
cmd_valid  input  1  cmd_byte is valid this cycle
cmd_byte  input  8  ASCII character
cmd_ready  output  1  byte accepted when cmd_valid && cmd_ready
set_hour  output  5  time/date load value, 0..23
set_min  output  6  time/date load value, 0..59
set_sec  output  6  time/date load value, 0..59
set_day  output  5  time/date load value, 1..31
set_month  output  4  time/date load value, 1..12
set_year  output  12  time/date load value, YEAR_MIN..YEAR_MAX
set_load  output  1  one-cycle strobe; drives the clock's reset/load input
alarm_hour  output  5  alarm time
alarm_min  output  6  alarm time
alarm_sec  output  6  alarm time
alarm_enable  output  1  level; armed alarm
timer_min  output  6  timer preset
timer_sec  output  6  timer preset
timer_start  output  1  one-cycle strobe to the clock's timer_enable
mode_24h  output  1  0 = 12-hour display (mode 1), 1 = 24-hour (mode 2)
cmd_error  output  1  one-cycle strobe on rejected command

Behaviour:
- Reset (synchronous, active-high; overrides all else):
  - State IDLE; cmd_ready=1.
  - set_* = 00:00:00, 1/1/YEAR_MIN.
  - All alarm_* and timer_* = 0; alarm_enable=0; mode_24h=0; all strobes=0.
- Command grammar:
  - Mode digit '0'..'6', then N fields, each exactly one space (0x20) followed by exactly two ASCII digits, terminated by LF (0x0A).
  - CR (0x0D) is ignored in every state.
  - Field count N by mode: 0→0, 1→0, 2→0, 3→6 (HH MM SS DD MO YY), 4→3 (HH MM SS, 24h), 5→2 (MM SS), 6→0.
- States:
  - IDLE: digit '0'..'6' → store mode, field_idx=0, go SEP_OR_END; LF → stay; other byte → ERR.
  - SEP_OR_END: space with field_idx<N → D_HI; LF with field_idx==N → EXEC; otherwise → ERR.
  - D_HI: digit → acc=10*d → D_LO; else → ERR.
  - D_LO: digit → field[field_idx]=acc+d, field_idx++ → SEP_OR_END; else → ERR.
  - ERR: discard bytes until LF, then pulse cmd_error for one cycle → IDLE.
  - EXEC: one cycle; cmd_ready=0; no byte accepted. Range-check fields and commit, or pulse cmd_error. → IDLE.
- Range checks: hour ≤23; min, sec ≤59; day 1..31; month 1..12; YEAR_BASE+YY within YEAR_MIN..YEAR_MAX. Day is not checked against month length; the clock owns calendar rules. Any failure → cmd_error; no output changes.
- Commit (registered; strobes high exactly one cycle, the cycle after EXEC):
  - mode 0: alarm_enable←0.
  - mode 1: mode_24h←0.
  - mode 2: mode_24h←1.
  - mode 3: set_*←fields; set_load pulse.
  - mode 4: alarm_*←fields; alarm_enable←1.
  - mode 5: timer_*←fields; timer_start pulse. 00 00 is accepted and still pulses.
  - mode 6: set_*←00:00:00 1/1/2024; set_load pulse.
- Latency: LF accepted at cycle T → EXEC at T+1 → outputs/strobes visible at T+2. cmd_ready returns high at T+2.
- Outputs not named in a commit hold their values. Fields of an aborted command never leak into outputs.
- cmd_valid while cmd_ready=0: byte is not consumed; the source holds it.
- Overflow: more fields than N → ERR; LF before N fields → cmd_error.
- Reset mid-command: partial command discarded, state IDLE.

Test Plan:
- Bytes "3 14 30 05 15 08 24\n" → 2 cycles after LF: set_hour=14, set_min=30, set_sec=5, set_day=15, set_month=8, set_year=2024; set_load high for exactly 1 cycle.
- "4 07 00 00\n" then "0\n" → alarm_hour=7, min=0, sec=0, alarm_enable=1; after second command alarm_enable=0 with alarm fields unchanged.
- "5 01 30\n" → timer_min=1, timer_sec=30, timer_start 1-cycle pulse; a second "5 01 30\n" pulses again.
- "3 24 00 00 01 01 24\n", "3 10 00 00 01 01 19\n", "4 07 00\n", "7\n", "4 7 00 00\n" → each gives one cmd_error pulse and no set_load/timer_start/alarm change; the following "2\n" sets mode_24h=1.
- "6\r\n" → set_* = 00:00:00 1/1/2024, set_load pulse (CR ignored); "1\n" → mode_24h=0.
- Reset asserted after "3 14 3" → all outputs at reset values; next "5 00 10\n" parsed correctly. Hold cmd_valid high across EXEC → byte accepted only when cmd_ready=1, none lost or duplicated.
